// File: rtl/core_bus_scheduler.sv
// Command scheduler between the instruction handler and NUM_CORES cores.
// Accepts one command at a time, decodes the owning core from the address,
// strobes that core for one cycle, waits RESULT_LATENCY cycles, then returns
// the core's result. Unmapped addresses are answered with an error response.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/ready_o     command handshake
//   cmd_instruction_i       opcode (0 = NOP)
//   cmd_address_i           global address
//   cmd_value_i             operand
//   rsp_valid_o             one-cycle response strobe
//   rsp_result_o            response result (held until next response)
//   rsp_error_o             response was for an unmapped address
//   core_sel_o              one-hot issue strobe
//   core_instruction_o      opcode to cores (0 when not issuing)
//   core_address_o          local offset within the core window
//   core_value_o            operand to cores
//   core_result_i           packed core results, core k at [k*DATA_W +: DATA_W]
//   core_stream_i           packed core stream words
//   stream_o                registered stream word of the last-addressed core
//   err_count_o             saturating count of unmapped commands
module core_bus_scheduler #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned CORE_SPAN      = 16,
  parameter int unsigned RESULT_LATENCY = 2,
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned INSTR_W        = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [INSTR_W-1:0]            cmd_instruction_i,
  input  logic [ADDR_W-1:0]             cmd_address_i,
  input  logic [DATA_W-1:0]             cmd_value_i,
  output logic                          rsp_valid_o,
  output logic [DATA_W-1:0]             rsp_result_o,
  output logic                          rsp_error_o,
  output logic [NUM_CORES-1:0]          core_sel_o,
  output logic [INSTR_W-1:0]            core_instruction_o,
  output logic [ADDR_W-1:0]             core_address_o,
  output logic [DATA_W-1:0]             core_value_o,
  input  logic [NUM_CORES*DATA_W-1:0]   core_result_i,
  input  logic [NUM_CORES*DATA_W-1:0]   core_stream_i,
  output logic [DATA_W-1:0]             stream_o,
  output logic [7:0]                    err_count_o
);

  localparam int unsigned SPAN_W = $clog2(CORE_SPAN);
  localparam int unsigned IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_result_q, rsp_result_d;
  logic                 rsp_error_q, rsp_error_d;
  logic [NUM_CORES-1:0] core_sel_q, core_sel_d;
  logic [INSTR_W-1:0]   core_instr_q, core_instr_d;
  logic [ADDR_W-1:0]    core_addr_q, core_addr_d;
  logic [DATA_W-1:0]    core_value_q, core_value_d;
  logic [DATA_W-1:0]    stream_q, stream_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  // Address decode: full-width window index so high addresses never alias core 0.
  logic [ADDR_W-1:0] win_idx_c;
  logic [ADDR_W-1:0] offset_c;
  logic              mapped_c;
  assign win_idx_c = cmd_address_i >> SPAN_W;
  assign offset_c  = cmd_address_i & ADDR_W'(CORE_SPAN - 1);
  assign mapped_c  = (win_idx_c < ADDR_W'(NUM_CORES));

  // Result and stream muxes selected by the latched / last-addressed index.
  logic [DATA_W-1:0] result_sel_c;
  always_comb begin
    result_sel_c = '0;
    stream_d     = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        result_sel_c = core_result_i[k*DATA_W +: DATA_W];
        stream_d     = core_stream_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      core_sel_q   <= '0;
      core_instr_q <= '0;
      core_addr_q  <= '0;
      core_value_q <= '0;
      stream_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      core_sel_q   <= core_sel_d;
      core_instr_q <= core_instr_d;
      core_addr_q  <= core_addr_d;
      core_value_q <= core_value_d;
      stream_q     <= stream_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rsp_valid_d  = 1'b0;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    core_sel_d   = '0;
    core_instr_d = '0;
    core_addr_d  = core_addr_q;
    core_value_d = core_value_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_instruction_i == '0) begin
            state_d      = RESPOND;
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_error_d  = 1'b0;
          end else if (!mapped_c) begin
            state_d      = RESPOND;
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_error_d  = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end else begin
            state_d      = ISSUE;
            idx_d        = IDX_W'(win_idx_c);
            core_sel_d   = NUM_CORES'(1) << IDX_W'(win_idx_c);
            core_instr_d = cmd_instruction_i;
            core_addr_d  = offset_c;
            core_value_d = cmd_value_i;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(RESULT_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        // Counter reaching 1 marks the last wait cycle, when the result is valid.
        if (cnt_q <= CNT_W'(1)) begin
          state_d      = RESPOND;
          rsp_valid_d  = 1'b1;
          rsp_result_d = result_sel_c;
          rsp_error_d  = 1'b0;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  assign cmd_ready_o        = ready_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_result_o       = rsp_result_q;
  assign rsp_error_o        = rsp_error_q;
  assign core_sel_o         = core_sel_q;
  assign core_instruction_o = core_instr_q;
  assign core_address_o     = core_addr_q;
  assign core_value_o       = core_value_q;
  assign stream_o           = stream_q;
  assign err_count_o        = err_cnt_q;

endmodule

// File: tb/tb_core_bus_scheduler.sv
module tb_core_bus_scheduler;

  localparam int unsigned NUM_CORES = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned INSTR_W   = 8;

  logic                        clk_i = 1'b0;
  logic                        rst_i = 1'b1;
  logic                        cmd_valid_i = 1'b0;
  logic                        cmd_ready_o;
  logic [INSTR_W-1:0]          cmd_instruction_i = '0;
  logic [ADDR_W-1:0]           cmd_address_i = '0;
  logic [DATA_W-1:0]           cmd_value_i = '0;
  logic                        rsp_valid_o;
  logic [DATA_W-1:0]           rsp_result_o;
  logic                        rsp_error_o;
  logic [NUM_CORES-1:0]        core_sel_o;
  logic [INSTR_W-1:0]          core_instruction_o;
  logic [ADDR_W-1:0]           core_address_o;
  logic [DATA_W-1:0]           core_value_o;
  logic [NUM_CORES*DATA_W-1:0] core_result_i;
  logic [NUM_CORES*DATA_W-1:0] core_stream_i;
  logic [DATA_W-1:0]           stream_o;
  logic [7:0]                  err_count_o;

  logic [DATA_W-1:0] res [NUM_CORES];
  logic [DATA_W-1:0] strm [NUM_CORES];
  assign core_result_i = {res[3], res[2], res[1], res[0]};
  assign core_stream_i = {strm[3], strm[2], strm[1], strm[0]};

  int n_checks = 0;
  int n_pass   = 0;

  core_bus_scheduler #(
    .NUM_CORES(4), .CORE_SPAN(16), .RESULT_LATENCY(2),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_instruction_i(cmd_instruction_i), .cmd_address_i(cmd_address_i),
    .cmd_value_i(cmd_value_i),
    .rsp_valid_o(rsp_valid_o), .rsp_result_o(rsp_result_o), .rsp_error_o(rsp_error_o),
    .core_sel_o(core_sel_o), .core_instruction_o(core_instruction_o),
    .core_address_o(core_address_o), .core_value_o(core_value_o),
    .core_result_i(core_result_i), .core_stream_i(core_stream_i),
    .stream_o(stream_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] ins, input logic [23:0] addr, input logic [31:0] val);
    cmd_valid_i       = 1'b1;
    cmd_instruction_i = ins;
    cmd_address_i     = addr;
    cmd_value_i       = val;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL reset_ready got=%0h exp=1", cmd_ready_o); else n_pass++;
    n_checks++; if (rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid_o); else n_pass++;
    n_checks++; if (core_sel_o !== 4'b0) $display("FAIL reset_core_sel got=%0h exp=0", core_sel_o); else n_pass++;
    n_checks++; if (rsp_result_o !== 32'h0) $display("FAIL reset_rsp_result got=%0h exp=0", rsp_result_o); else n_pass++;
    n_checks++; if (err_count_o !== 8'h0) $display("FAIL reset_err_count got=%0h exp=0", err_count_o); else n_pass++;
    n_checks++; if (stream_o !== 32'h0) $display("FAIL reset_stream got=%0h exp=0", stream_o); else n_pass++;
    rst_i = 1'b0;
  endtask

  task automatic test_mapped();
    res[1] = 32'hBAD0BAD0;
    drive_cmd(8'h01, 24'h000012, 32'hDEADBEEF);
    tick(); // T+1: ISSUE
    cmd_valid_i = 1'b0;
    n_checks++; if (core_sel_o !== 4'b0010) $display("FAIL map_sel got=%0b exp=0010", core_sel_o); else n_pass++;
    n_checks++; if (core_address_o !== 24'h2) $display("FAIL map_addr got=%0h exp=2", core_address_o); else n_pass++;
    n_checks++; if (core_value_o !== 32'hDEADBEEF) $display("FAIL map_value got=%0h exp=deadbeef", core_value_o); else n_pass++;
    n_checks++; if (core_instruction_o !== 8'h01) $display("FAIL map_instr got=%0h exp=1", core_instruction_o); else n_pass++;
    n_checks++; if (cmd_ready_o !== 1'b0) $display("FAIL map_ready_busy got=%0h exp=0", cmd_ready_o); else n_pass++;
    tick(); // T+2: WAIT
    n_checks++; if (core_sel_o !== 4'b0 || core_instruction_o !== 8'h0) $display("FAIL map_wait_idle_bus got=%0b/%0h exp=0/0", core_sel_o, core_instruction_o); else n_pass++;
    n_checks++; if (core_address_o !== 24'h2) $display("FAIL map_wait_addr_hold got=%0h exp=2", core_address_o); else n_pass++;
    tick(); // T+3: result valid this cycle only
    res[1] = 32'h12345678;
    n_checks++; if (rsp_valid_o !== 1'b0) $display("FAIL map_early_rsp got=%0h exp=0", rsp_valid_o); else n_pass++;
    tick(); // T+4: RESPOND
    res[1] = 32'hBAD1BAD1;
    n_checks++; if (rsp_valid_o !== 1'b1) $display("FAIL map_rsp_valid got=%0h exp=1", rsp_valid_o); else n_pass++;
    n_checks++; if (rsp_result_o !== 32'h12345678) $display("FAIL map_rsp_result got=%0h exp=12345678", rsp_result_o); else n_pass++;
    n_checks++; if (rsp_error_o !== 1'b0) $display("FAIL map_rsp_error got=%0h exp=0", rsp_error_o); else n_pass++;
    tick(); // T+5: IDLE
    n_checks++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) $display("FAIL map_after valid=%0h ready=%0h exp=0/1", rsp_valid_o, cmd_ready_o); else n_pass++;
    n_checks++; if (rsp_result_o !== 32'h12345678) $display("FAIL map_result_hold got=%0h exp=12345678", rsp_result_o); else n_pass++;
  endtask

  task automatic test_unmapped();
    int sel_seen = 0;
    drive_cmd(8'h02, 24'h000040, 32'h1);
    tick();
    cmd_valid_i = 1'b0;
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_error_o !== 1'b1) $display("FAIL unm_rsp valid=%0h err=%0h exp=1/1", rsp_valid_o, rsp_error_o); else n_pass++;
    n_checks++; if (rsp_result_o !== 32'h0) $display("FAIL unm_result got=%0h exp=0", rsp_result_o); else n_pass++;
    n_checks++; if (core_sel_o !== 4'b0) $display("FAIL unm_sel got=%0b exp=0", core_sel_o); else n_pass++;
    n_checks++; if (err_count_o !== 8'd1) $display("FAIL unm_err_count got=%0d exp=1", err_count_o); else n_pass++;
    tick();
    n_checks++; if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) $display("FAIL unm_back_idle ready=%0h valid=%0h exp=1/0", cmd_ready_o, rsp_valid_o); else n_pass++;
    for (int i = 0; i < 299; i++) begin
      drive_cmd(8'h02, (i % 2 == 0) ? 24'hFFFFFF : 24'h000050, 32'h0);
      tick();
      cmd_valid_i = 1'b0;
      if (core_sel_o !== 4'b0 || rsp_error_o !== 1'b1) sel_seen++;
      tick();
    end
    n_checks++; if (sel_seen !== 0) $display("FAIL unm_loop_bad_rsp got=%0d exp=0", sel_seen); else n_pass++;
    n_checks++; if (err_count_o !== 8'd255) $display("FAIL unm_saturate got=%0d exp=255", err_count_o); else n_pass++;
  endtask

  task automatic test_nop();
    drive_cmd(8'h00, 24'h000000, 32'h55);
    tick();
    cmd_valid_i = 1'b0;
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_error_o !== 1'b0) $display("FAIL nop_rsp valid=%0h err=%0h exp=1/0", rsp_valid_o, rsp_error_o); else n_pass++;
    n_checks++; if (rsp_result_o !== 32'h0) $display("FAIL nop_result got=%0h exp=0", rsp_result_o); else n_pass++;
    n_checks++; if (core_sel_o !== 4'b0) $display("FAIL nop_sel got=%0b exp=0", core_sel_o); else n_pass++;
    n_checks++; if (err_count_o !== 8'd255) $display("FAIL nop_err_count got=%0d exp=255", err_count_o); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    res[3] = 32'hA3A3A3A3;
    res[0] = 32'h0B0B0B0B;
    drive_cmd(8'h03, 24'h000035, 32'h00001111);
    tick(); // T+1
    drive_cmd(8'h04, 24'h000007, 32'h00002222);
    n_checks++; if (core_sel_o !== 4'b1000 || core_address_o !== 24'h5) $display("FAIL b2b_first sel=%0b addr=%0h exp=1000/5", core_sel_o, core_address_o); else n_pass++;
    n_checks++; if (cmd_ready_o !== 1'b0) $display("FAIL b2b_ready_t1 got=%0h exp=0", cmd_ready_o); else n_pass++;
    tick(); // T+2
    n_checks++; if (cmd_ready_o !== 1'b0 || core_sel_o !== 4'b0) $display("FAIL b2b_t2 ready=%0h sel=%0b exp=0/0", cmd_ready_o, core_sel_o); else n_pass++;
    tick(); // T+3
    n_checks++; if (cmd_ready_o !== 1'b0) $display("FAIL b2b_ready_t3 got=%0h exp=0", cmd_ready_o); else n_pass++;
    tick(); // T+4
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hA3A3A3A3) $display("FAIL b2b_rsp1 valid=%0h res=%0h exp=1/a3a3a3a3", rsp_valid_o, rsp_result_o); else n_pass++;
    n_checks++; if (cmd_ready_o !== 1'b0) $display("FAIL b2b_ready_t4 got=%0h exp=0", cmd_ready_o); else n_pass++;
    tick(); // T+5: first IDLE cycle, second command accepted at its closing edge
    n_checks++; if (cmd_ready_o !== 1'b1 || core_sel_o !== 4'b0) $display("FAIL b2b_t5 ready=%0h sel=%0b exp=1/0", cmd_ready_o, core_sel_o); else n_pass++;
    tick(); // T+6: ISSUE of second command
    cmd_valid_i = 1'b0;
    n_checks++; if (core_sel_o !== 4'b0001 || core_address_o !== 24'h7 || core_value_o !== 32'h2222) $display("FAIL b2b_second sel=%0b addr=%0h val=%0h exp=0001/7/2222", core_sel_o, core_address_o, core_value_o); else n_pass++;
    n_checks++; if (core_instruction_o !== 8'h04) $display("FAIL b2b_second_instr got=%0h exp=4", core_instruction_o); else n_pass++;
    tick();
    tick();
    tick(); // T+9
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h0B0B0B0B) $display("FAIL b2b_rsp2 valid=%0h res=%0h exp=1/0b0b0b0b", rsp_valid_o, rsp_result_o); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    res[1] = 32'h77777777;
    drive_cmd(8'h09, 24'h00001C, 32'hABCD0123);
    tick(); // ISSUE
    cmd_valid_i = 1'b0;
    tick(); // WAIT
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) $display("FAIL rmid_state valid=%0h ready=%0h exp=0/1", rsp_valid_o, cmd_ready_o); else n_pass++;
    n_checks++; if (core_address_o !== 24'h0 || core_value_o !== 32'h0 || core_instruction_o !== 8'h0) $display("FAIL rmid_core_bus addr=%0h val=%0h ins=%0h exp=0/0/0", core_address_o, core_value_o, core_instruction_o); else n_pass++;
    n_checks++; if (err_count_o !== 8'h0 || rsp_result_o !== 32'h0) $display("FAIL rmid_clear err=%0h res=%0h exp=0/0", err_count_o, rsp_result_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid_o !== 1'b0 || core_sel_o !== 4'b0) stray++;
    end
    n_checks++; if (stray !== 0) $display("FAIL rmid_stray_activity got=%0d exp=0", stray); else n_pass++;
    res[2] = 32'h22222222;
    drive_cmd(8'h05, 24'h000021, 32'h00000005);
    tick();
    cmd_valid_i = 1'b0;
    n_checks++; if (core_sel_o !== 4'b0100 || core_address_o !== 24'h1) $display("FAIL rmid_new_issue sel=%0b addr=%0h exp=0100/1", core_sel_o, core_address_o); else n_pass++;
    tick();
    tick();
    tick();
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h22222222) $display("FAIL rmid_new_rsp valid=%0h res=%0h exp=1/22222222", rsp_valid_o, rsp_result_o); else n_pass++;
    tick();
  endtask

  task automatic test_stream();
    strm[2] = 32'hCAFEF00D;
    tick();
    n_checks++; if (stream_o !== 32'hCAFEF00D) $display("FAIL stream_follow got=%0h exp=cafef00d", stream_o); else n_pass++;
    strm[0] = 32'h13579BDF;
    tick();
    n_checks++; if (stream_o !== 32'hCAFEF00D) $display("FAIL stream_other_core got=%0h exp=cafef00d", stream_o); else n_pass++;
    strm[2] = 32'h0F0F0F0F;
    tick();
    n_checks++; if (stream_o !== 32'h0F0F0F0F) $display("FAIL stream_update got=%0h exp=0f0f0f0f", stream_o); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < NUM_CORES; k++) begin
      res[k]  = '0;
      strm[k] = '0;
    end
    test_reset();
    test_mapped();
    test_unmapped();
    test_nop();
    test_back_to_back();
    test_reset_mid();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
